// File: rtl/pu_or1k_pfpu_pkg.sv
// Shared types and constant helpers for the pfpu arithmetic units.
// Covers the rounding-mode encoding, the operand classes and the exponent/shift limits.
package pu_or1k_pfpu_pkg;

    typedef enum logic [1:0] {
        RNE = 2'd0,
        RTZ = 2'd1,
        RUP = 2'd2,
        RDN = 2'd3
    } rmode_e;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORMAL,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } opclass_e;

    function automatic int f2i_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Any right shift past this leaves the whole mantissa below the guard bit.
    function automatic int f2i_rsh_max(input int frac_w);
        return frac_w + 2;
    endfunction

    // Unbiased shift beyond this puts the leading one at or above bit int_w.
    function automatic int f2i_ovf_lim(input int int_w, input int frac_w);
        return int_w - 1 - frac_w;
    endfunction

endpackage

// File: rtl/pu_or1k_pfpu_f2i_rnd.sv
// Float-to-int stage 3: rounding increment, range check, saturation and negation.
// Purely combinational; the parent owns the stage-3 register.
module pu_or1k_pfpu_f2i_rnd
    import pu_or1k_pfpu_pkg::*;
#(
    parameter int INT_W = 32
) (
    input  opclass_e         cls_i,
    input  logic             sign_i,
    input  logic [INT_W:0]   mag_i,
    input  logic             guard_i,
    input  logic             sticky_i,
    input  logic             preovf_i,
    input  rmode_e           rmode_i,
    input  logic             unsigned_i,
    input  logic             fract_nz_i,
    output logic [INT_W-1:0] result_o,
    output logic             inv_o,
    output logic             ix_o,
    output logic             snan_o
);

    localparam logic [INT_W:0]   SPOS_LIM = {2'b00, {(INT_W-1){1'b1}}};
    localparam logic [INT_W:0]   SNEG_LIM = {2'b01, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] POS_MAX  = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] NEG_MAX  = {1'b1, {(INT_W-1){1'b0}}};

    logic             inexact;
    logic             inc;
    logic [INT_W:0]   sum;
    logic             in_rng;
    logic [INT_W-1:0] sat_val;

    // NOTE: every output is given a default before the case so no path infers a latch.
    always_comb begin
        inexact = guard_i | sticky_i;
        case (rmode_i)
            RNE:     inc = guard_i & (sticky_i | mag_i[0]);
            RTZ:     inc = 1'b0;
            RUP:     inc = ~sign_i & inexact;
            default: inc = sign_i & inexact;
        endcase
        sum = mag_i + {{INT_W{1'b0}}, inc};

        if (unsigned_i) begin
            in_rng = sign_i ? (sum == '0) : ~sum[INT_W];
        end else begin
            in_rng = sign_i ? (sum <= SNEG_LIM) : (sum <= SPOS_LIM);
        end
        in_rng = in_rng & ~preovf_i;

        if (unsigned_i) begin
            sat_val = sign_i ? '0 : '1;
        end else begin
            sat_val = sign_i ? NEG_MAX : POS_MAX;
        end

        result_o = '0;
        inv_o    = 1'b0;
        ix_o     = 1'b0;
        snan_o   = 1'b0;
        case (cls_i)
            CLS_QNAN, CLS_SNAN: begin
                result_o = unsigned_i ? '1 : POS_MAX;
                inv_o    = 1'b1;
                snan_o   = (cls_i == CLS_SNAN);
            end
            CLS_ZERO, CLS_DENORM: begin
                ix_o = fract_nz_i;
            end
            CLS_INF: begin
                result_o = sat_val;
                inv_o    = 1'b1;
            end
            default: begin
                if (in_rng) begin
                    result_o = sign_i ? -sum[INT_W-1:0] : sum[INT_W-1:0];
                    ix_o     = inexact;
                end else begin
                    result_o = sat_val;
                    inv_o    = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/pu_or1k_pfpu_f2i_pipe.sv
// Three-stage float-to-integer converter: classify/shift-select, align, round/saturate.
// Stages move together on adv_i; flush_i drops every in-flight operation.
module pu_or1k_pfpu_f2i_pipe
    import pu_or1k_pfpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int INT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    adv_i,
    input  logic                    start_i,
    input  logic [EXP_W+FRAC_W:0]   opa_i,
    input  logic [1:0]              rmode_i,
    input  logic                    unsigned_i,
    output logic                    rdy_o,
    output logic [INT_W-1:0]        result_o,
    output logic                    inv_o,
    output logic                    ix_o,
    output logic                    snan_o
);

    localparam int OP_W    = EXP_W + FRAC_W + 1;
    localparam int MANT_W  = FRAC_W + 1;
    localparam int MAG_W   = INT_W + 1;
    localparam int E_W     = EXP_W + 2;
    localparam int BIAS    = f2i_bias(EXP_W);
    localparam int RSH_MAX = f2i_rsh_max(FRAC_W);
    localparam int OVF_LIM = f2i_ovf_lim(INT_W, FRAC_W);
    localparam int SH_W    = $clog2(((INT_W > RSH_MAX) ? INT_W : RSH_MAX) + 1);
    localparam int WIDE_W  = MANT_W + FRAC_W + 2;

    typedef struct packed {
        opclass_e          cls;
        logic              sign;
        logic [MANT_W-1:0] mant;
        logic              lsh;
        logic [SH_W-1:0]   shamt;
        logic              preovf;
        rmode_e            rmode;
        logic              uns;
        logic              fract_nz;
    } s1_t;

    typedef struct packed {
        opclass_e          cls;
        logic              sign;
        logic [MAG_W-1:0]  mag;
        logic              guard;
        logic              sticky;
        logic              preovf;
        rmode_e            rmode;
        logic              uns;
        logic              fract_nz;
    } s2_t;

    logic ld;
    logic v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
    s1_t  s1_new, s1_d, s1_q;
    s2_t  s2_new, s2_d, s2_q;

    logic [EXP_W-1:0]       exp_w;
    logic [FRAC_W-1:0]      fract_w;
    logic signed [E_W-1:0]  e_w;
    int                     e_i;
    logic [WIDE_W-1:0]      wide_w;

    logic [INT_W-1:0] rnd_result;
    logic             rnd_inv, rnd_ix, rnd_snan;
    logic [INT_W-1:0] result_d, result_q;
    logic             inv_d, inv_q, ix_d, ix_q, snan_d, snan_q;

    always_comb begin
        ld   = adv_i & ~flush_i;
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        if (flush_i) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
            v3_d = 1'b0;
        end else if (adv_i) begin
            v1_d = start_i;
            v2_d = v1_q;
            v3_d = v2_q;
        end
    end

    // S1: classify and pick shift direction/amount from the unbiased exponent.
    always_comb begin
        exp_w   = opa_i[FRAC_W +: EXP_W];
        fract_w = opa_i[FRAC_W-1:0];
        e_w     = $signed({2'b00, exp_w}) - $signed(E_W'(BIAS + FRAC_W));
        e_i     = int'(e_w);

        s1_new          = '0;
        s1_new.sign     = opa_i[OP_W-1];
        s1_new.rmode    = rmode_e'(rmode_i);
        s1_new.uns      = unsigned_i;
        s1_new.fract_nz = |fract_w;
        s1_new.mant     = {|exp_w, fract_w};

        if (exp_w == '0) begin
            s1_new.cls = (|fract_w) ? CLS_DENORM : CLS_ZERO;
        end else if (&exp_w) begin
            if (fract_w == '0)          s1_new.cls = CLS_INF;
            else if (fract_w[FRAC_W-1]) s1_new.cls = CLS_QNAN;
            else                        s1_new.cls = CLS_SNAN;
        end else begin
            s1_new.cls = CLS_NORMAL;
        end

        if (e_i >= 0) begin
            s1_new.lsh    = 1'b1;
            s1_new.shamt  = SH_W'((e_i > INT_W) ? INT_W : e_i);
            s1_new.preovf = (e_i > OVF_LIM);
        end else begin
            s1_new.lsh    = 1'b0;
            s1_new.shamt  = SH_W'((-e_i > RSH_MAX) ? RSH_MAX : -e_i);
        end

        s1_d = ld ? s1_new : s1_q;
    end

    // S2: align into integer magnitude with guard and sticky below it.
    always_comb begin
        s2_new          = '0;
        s2_new.cls      = s1_q.cls;
        s2_new.sign     = s1_q.sign;
        s2_new.preovf   = s1_q.preovf;
        s2_new.rmode    = s1_q.rmode;
        s2_new.uns      = s1_q.uns;
        s2_new.fract_nz = s1_q.fract_nz;

        wide_w = {s1_q.mant, {(FRAC_W+2){1'b0}}} >> s1_q.shamt;
        if (s1_q.lsh) begin
            s2_new.mag = {{(MAG_W-MANT_W){1'b0}}, s1_q.mant} << s1_q.shamt;
        end else begin
            s2_new.mag    = {{(MAG_W-MANT_W){1'b0}}, wide_w[WIDE_W-1 -: MANT_W]};
            s2_new.guard  = wide_w[FRAC_W+1];
            s2_new.sticky = |wide_w[FRAC_W:0];
        end

        s2_d = ld ? s2_new : s2_q;
    end

    pu_or1k_pfpu_f2i_rnd #(
        .INT_W (INT_W)
    ) u_rnd (
        .cls_i      (s2_q.cls),
        .sign_i     (s2_q.sign),
        .mag_i      (s2_q.mag),
        .guard_i    (s2_q.guard),
        .sticky_i   (s2_q.sticky),
        .preovf_i   (s2_q.preovf),
        .rmode_i    (s2_q.rmode),
        .unsigned_i (s2_q.uns),
        .fract_nz_i (s2_q.fract_nz),
        .result_o   (rnd_result),
        .inv_o      (rnd_inv),
        .ix_o       (rnd_ix),
        .snan_o     (rnd_snan)
    );

    always_comb begin
        result_d = result_q;
        inv_d    = inv_q;
        ix_d     = ix_q;
        snan_d   = snan_q;
        if (ld) begin
            result_d = rnd_result;
            inv_d    = rnd_inv;
            ix_d     = rnd_ix;
            snan_d   = rnd_snan;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            result_q <= '0;
            inv_q    <= 1'b0;
            ix_q     <= 1'b0;
            snan_q   <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            result_q <= result_d;
            inv_q    <= inv_d;
            ix_q     <= ix_d;
            snan_q   <= snan_d;
        end
    end

    // NOTE: S1/S2 data needs no reset; nothing reads it unless its stage valid is set.
    always_ff @(posedge clk) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
    end

    assign rdy_o    = v3_q;
    assign result_o = result_q;
    assign inv_o    = inv_q;
    assign ix_o     = ix_q;
    assign snan_o   = snan_q;

endmodule
